// File: rtl/led_pwm_driver.sv
// Drives the board LED pins from the registered ledout pattern, applying a
// global PWM brightness and an optional blink, both set through a bus register.
module led_pwm_driver #(
    parameter int WIDTH         = 24,
    parameter int PRESCALE      = 1000,
    parameter int PWM_BITS      = 4,
    parameter int BLINK_PERIODS = 64
) (
    input  logic             led_clk,
    input  logic             ledrst_n,
    input  logic [WIDTH-1:0] ledin,
    input  logic             pwmcs,
    input  logic             pwmwrite,
    input  logic [15:0]      pwmwdata,
    output logic [15:0]      pwmrdata,
    output logic [WIDTH-1:0] ledpins
);

    localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_pend;
    logic                blink_en;
    logic                blink_en_pend;

    logic step;
    logic boundary;
    logic on;
    logic wr_en;
    logic unused_wdata;

    assign step     = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign boundary = step && (pwm_cnt == {PWM_BITS{1'b1}});
    assign wr_en    = pwmcs && pwmwrite;

    // Full-scale duty means 100 % lit, not (2**PWM_BITS-1)/2**PWM_BITS.
    assign on = (duty == {PWM_BITS{1'b1}}) || (pwm_cnt < duty);

    assign unused_wdata = ^pwmwdata;

    always_comb begin
        pwmrdata                 = '0;
        pwmrdata[PWM_BITS-1:0]   = duty_pend;
        pwmrdata[8]              = blink_en_pend;
    end

    always_ff @(posedge led_clk) begin
        if (!ledrst_n) begin
            pre_cnt       <= '0;
            pwm_cnt       <= '0;
            blink_cnt     <= '0;
            blink_phase   <= 1'b1;
            duty          <= '1;
            duty_pend     <= '1;
            blink_en      <= 1'b0;
            blink_en_pend <= 1'b0;
            ledpins       <= '0;
        end else begin
            ledpins <= ledin & {WIDTH{on & blink_phase}};

            pre_cnt <= step ? '0 : pre_cnt + 1'b1;
            if (step) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end

            // Live settings only change at a period boundary; a write landing
            // on the boundary itself waits for the following one.
            if (boundary) begin
                duty     <= duty_pend;
                blink_en <= blink_en_pend;
                if (blink_en_pend) begin
                    if (blink_cnt == BLINK_W'(BLINK_PERIODS - 1)) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end else begin
                    blink_cnt   <= '0;
                    blink_phase <= 1'b1;
                end
            end

            if (wr_en) begin
                duty_pend     <= pwmwdata[PWM_BITS-1:0];
                blink_en_pend <= pwmwdata[8];
            end
        end
    end

endmodule
